// File: rtl/hazard3_timer_pkg.sv
// rtl/hazard3_timer_pkg.sv - shared register map, hart limits and address decode for the machine timer
package hazard3_timer_pkg;

    localparam int MAX_HARTS  = 8;
    localparam int HART_IDX_W = 3;
    localparam int HART_SHIFT = 3;

    localparam logic [15:0] HART_STRIDE    = 16'(1 << HART_SHIFT);
    localparam logic [15:0] ADDR_CTRL      = 16'h0000;
    localparam logic [15:0] ADDR_PRESCALE  = 16'h0004;
    localparam logic [15:0] ADDR_MTIME     = 16'h0008;
    localparam logic [15:0] ADDR_MTIMEH    = 16'h000c;
    localparam logic [15:0] ADDR_MTIMECMP  = 16'h0010;
    localparam logic [15:0] ADDR_CMP_END   = ADDR_MTIMECMP + 16'(MAX_HARTS) * HART_STRIDE;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_PRESCALE,
        SEL_MTIME,
        SEL_MTIMEH,
        SEL_CMP,
        SEL_CMPH
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e              sel;
        logic [HART_IDX_W-1:0] hart;
    } reg_dec_t;

    // Compare registers sit in a strided window; the low word of each pair is
    // at the stride boundary and the high word 4 bytes above it.
    function automatic reg_dec_t decode_addr(input logic [15:0] addr);
        reg_dec_t    dec;
        logic [15:0] ofs;
        dec.sel  = SEL_NONE;
        dec.hart = '0;
        ofs      = addr - ADDR_MTIMECMP;
        if (addr == ADDR_CTRL) begin
            dec.sel = SEL_CTRL;
        end else if (addr == ADDR_PRESCALE) begin
            dec.sel = SEL_PRESCALE;
        end else if (addr == ADDR_MTIME) begin
            dec.sel = SEL_MTIME;
        end else if (addr == ADDR_MTIMEH) begin
            dec.sel = SEL_MTIMEH;
        end else if (addr >= ADDR_MTIMECMP && addr < ADDR_CMP_END && addr[1:0] == 2'b00) begin
            dec.hart = HART_IDX_W'(ofs >> HART_SHIFT);
            dec.sel  = ofs[2] ? SEL_CMPH : SEL_CMP;
        end
        return dec;
    endfunction

endpackage

// File: rtl/hazard3_sync_1bit.sv
// rtl/hazard3_sync_1bit.sv - multi-flop synchroniser for a single asynchronous bit
// Ports: clk, rst (async active-high), d_i async input, q_o synchronised output.
module hazard3_sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[N_STAGES-1];

endmodule

// File: rtl/hazard3_timer_cmp.sv
// rtl/hazard3_timer_cmp.sv - one hart's 64-bit mtimecmp register and registered timer interrupt
// Ports: clk, rst, wr_lo_i/wr_hi_i half write strobes, wdata_i write data,
//        mtime_i current mtime, cmp_o compare value for readback, irq_o interrupt.
module hazard3_timer_cmp (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] mtime_i,
    output logic [63:0] cmp_o,
    output logic        irq_o
);

    logic [63:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;

    // The interrupt compares against the registered compare value, so a
    // compare write becomes visible on the interrupt one cycle later still.
    always_comb begin
        cmp_d = cmp_q;
        if (wr_lo_i) cmp_d[31:0]  = wdata_i;
        if (wr_hi_i) cmp_d[63:32] = wdata_i;
        irq_d = (mtime_i >= cmp_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cmp_o = cmp_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/hazard3_riscv_timer_mh.sv
// rtl/hazard3_riscv_timer_mh.sv - multi-hart RISC-V machine timer with APB register access
// Ports: clk, rst (async active-high); APB paddr/psel/penable/pwrite/pwdata in,
//        prdata/pready/pslverr out; dbg_halt freezes counting; tick timebase;
//        timer_irq one registered interrupt per hart.
// Optional prescaler enabled by defining HAZARD3_TIMER_PRESCALER_EN.
module hazard3_riscv_timer_mh
    import hazard3_timer_pkg::*;
#(
    parameter int N_HARTS     = 1,
    parameter int TICK_IS_NRZ = 0,
    parameter int PRESCALE_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        paddr,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic               dbg_halt,
    input  logic               tick,
    output logic [N_HARTS-1:0] timer_irq
);

    reg_dec_t dec;
    logic     bus_wr;
    logic     tick_evt, tick_qual, mtime_inc;
    logic     en_q, en_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_val [N_HARTS];
    logic [PRESCALE_W-1:0] prescale_rd;

    assign dec     = decode_addr(paddr);
    assign bus_wr  = psel && penable && pwrite;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    // An NRZ tick is asynchronous: every toggle after synchronisation is one event.
    generate
        if (TICK_IS_NRZ != 0) begin : g_nrz
            logic tick_sync, tick_prev_q;
            hazard3_sync_1bit #(.N_STAGES(2)) u_sync (
                .clk (clk),
                .rst (rst),
                .d_i (tick),
                .q_o (tick_sync)
            );
            always_ff @(posedge clk or posedge rst) begin
                if (rst) tick_prev_q <= 1'b0;
                else     tick_prev_q <= tick_sync;
            end
            assign tick_evt = tick_sync ^ tick_prev_q;
        end else begin : g_level
            assign tick_evt = tick;
        end
    endgenerate

    assign tick_qual = tick_evt && en_q && !dbg_halt;

`ifdef HAZARD3_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;

    // Counter runs 0..prescale; a divider write restarts it and swallows a coincident tick.
    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        mtime_inc  = 1'b0;
        if (bus_wr && dec.sel == SEL_PRESCALE) begin
            prescale_d = pwdata[PRESCALE_W-1:0];
            pcnt_d     = '0;
        end else if (tick_qual) begin
            if (pcnt_q == prescale_q) begin
                pcnt_d    = '0;
                mtime_inc = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign prescale_rd = prescale_q;
`else
    assign mtime_inc   = tick_qual;
    assign prescale_rd = '0;
`endif

    // A half-word write overrides only its half; the other half keeps the incremented value.
    always_comb begin
        en_d = en_q;
        if (bus_wr && dec.sel == SEL_CTRL) en_d = pwdata[0];
        mtime_d = mtime_q + {63'd0, mtime_inc};
        if (bus_wr && dec.sel == SEL_MTIME)  mtime_d[31:0]  = pwdata;
        if (bus_wr && dec.sel == SEL_MTIMEH) mtime_d[63:32] = pwdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b1;
            mtime_q <= '0;
        end else begin
            en_q    <= en_d;
            mtime_q <= mtime_d;
        end
    end

    generate
        for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
            hazard3_timer_cmp u_cmp (
                .clk     (clk),
                .rst     (rst),
                .wr_lo_i (bus_wr && dec.sel == SEL_CMP  && dec.hart == HART_IDX_W'(h)),
                .wr_hi_i (bus_wr && dec.sel == SEL_CMPH && dec.hart == HART_IDX_W'(h)),
                .wdata_i (pwdata),
                .mtime_i (mtime_q),
                .cmp_o   (cmp_val[h]),
                .irq_o   (timer_irq[h])
            );
        end
    endgenerate

    // Harts beyond N_HARTS match no loop iteration and therefore read zero.
    always_comb begin
        prdata = '0;
        case (dec.sel)
            SEL_CTRL:     prdata = {31'd0, en_q};
            SEL_PRESCALE: prdata = 32'(prescale_rd);
            SEL_MTIME:    prdata = mtime_q[31:0];
            SEL_MTIMEH:   prdata = mtime_q[63:32];
            SEL_CMP, SEL_CMPH: begin
                for (int h = 0; h < N_HARTS; h++) begin
                    if (dec.hart == HART_IDX_W'(h)) begin
                        prdata = (dec.sel == SEL_CMPH) ? cmp_val[h][63:32] : cmp_val[h][31:0];
                    end
                end
            end
            default:      prdata = '0;
        endcase
    end

endmodule
